rand_scheduler: RTL and testbench
=================================

Name: rand_scheduler

Overview:
Shares one 8-bit LFSR random source among NREQ game-logic requesters. Arbitrates requests round-robin and steps the LFSR only while serving a grant. Builds an OUT_W-bit random word from successive 2-bit LFSR draws, then returns it with a one-cycle ack to the granted requester. Sits between the LFSR (which gains a step-enable/load interface) and the slave-side game FSMs.

Parameters:
NREQ, 4, number of requesters (2..8)
OUT_W, 8, random word width; even, >=2; DRAWS = OUT_W/2 LFSR steps per word

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
req  in  NREQ  per-requester request level
ack  out  NREQ  one-hot, one-cycle pulse: rand_data is valid for that requester
rand_data  out  OUT_W  random word; valid only in the ack cycle
lfsr_bits  in  2  current LFSR output bits [7:6]
lfsr_en  out  1  step LFSR at the next clk edge
lfsr_load  out  1  load lfsr_seed into LFSR at the next clk edge
lfsr_seed  out  8  seed value

Behaviour:
- Reset (rst=0, async): state=IDLE; ack=0; rand_data=0; lfsr_en=0; lfsr_load=0; cnt=0; acc=0; last_grant=NREQ-1, so req[0] wins first.
- FSM IDLE/DRAW/DONE, registered state.
- IDLE:
  - If any req is high, grant the first set bit searching upward from last_grant+1 (mod NREQ).
  - Latch the grant index g, clear cnt, go to DRAW.
  - If no req is high, stay in IDLE.
- DRAW:
  - lfsr_en=1 combinationally.
  - Each cycle: acc <= {acc[OUT_W-3:0], lfsr_bits}. The bits are sampled before the step, so the first draw uses the seed's top bits. cnt++.
  - After DRAWS cycles, go to DONE.
- DONE:
  - ack[g]=1 and rand_data=acc, both registered outputs visible this cycle.
  - last_grant<=g; go to IDLE.
  - lfsr_en=0.
- Latency: req sampled in IDLE at cycle t; DRAW runs t+1..t+DRAWS; ack at t+DRAWS+1. Back-to-back grants therefore repeat every DRAWS+2 cycles.
- Handshake:
  - The requester holds req until ack, then drops it the cycle after ack.
  - If req is still high when IDLE is re-entered, it counts as a new request, subject to round-robin.
- req[g] dropping during DRAW: abort and return to IDLE. No ack is issued and last_grant is unchanged. LFSR steps already taken are not undone.
- Requests from non-granted requesters that arrive during DRAW/DONE wait. They are never lost while held.
- LFSR is never stepped outside DRAW, so the output sequence is deterministic from the seed.
- Reset asserted mid-DRAW: immediate return to reset values; the partial word is discarded.

Optional Feature:
RAND_RESEED_EN
- Defined:
  - Adds input port reseed (1-bit pulse) and a free-running 8-bit cycle counter.
  - A reseed pulse sets a pending flag.
  - In IDLE, pending has priority over granting: lfsr_load=1 for one cycle with lfsr_seed = counter | 8'h01 (never zero, which would lock up the LFSR). Pending then clears and no grant is made that cycle.
  - A reseed during DRAW/DONE stays pending until IDLE.
- Undefined: no reseed port; lfsr_load tied 0; lfsr_seed tied 8'hBD.

Decomposition:
- Package rand_pkg:
  - state enum {IDLE, DRAW, DONE}
  - SEED_DEFAULT=8'hBD
  - grant-index width function (clog2 NREQ)
- Sub-module rr_pick: combinational round-robin picker; inputs req, last_grant; outputs found, idx.

Test Plan:
- LFSR at seed BD, req=4'b0001 held until ack -> lfsr_en high exactly 4 cycles, ack=4'b0001 on cycle 5, rand_data=8'h9F.
- Same requester re-requests immediately -> second word 8'hE7, ack 6 cycles after the first.
- req=4'b1111 held continuously -> ack order 0,1,2,3,0 at 6-cycle spacing; no requester skipped.
- req[2] alone, dropped after 2 DRAW cycles -> no ack, FSM back to IDLE, LFSR advanced 2 steps; a following req[0] grant uses the advanced state.
- rst pulled low mid-DRAW -> ack=0, lfsr_en=0, rand_data=0 immediately; the next req[0] after release is granted first.
- RAND_RESEED_EN: reseed pulse during DRAW -> lfsr_load=1 in the first IDLE cycle after ack with seed LSB=1; a pending req is granted on the following cycle.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared definitions for the random-word scheduler: FSM encoding, default LFSR seed
// and the grant-index width helper.
package rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] DRAW = ST_DRAW;
  localparam logic [1:0] DONE = ST_DONE;

  localparam logic [7:0] SEED_DEFAULT = 8'hBD;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from
// last_grant+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IW'((int'(last_grant) + i) % NREQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rand_scheduler.sv
// Shares one 8-bit LFSR among NREQ requesters; builds OUT_W-bit words from 2-bit draws.
// Optional RAND_RESEED_EN adds a reseed input that reloads the LFSR from a cycle counter.
//
// state | meaning
// IDLE  | waiting; reseed load or round-robin grant
// DRAW  | stepping LFSR, shifting 2 bits per cycle into acc
// DONE  | ack/rand_data registered for the granted requester
module rand_scheduler
  import rand_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RAND_RESEED_EN
  input  logic             reseed,
`endif
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [OUT_W-1:0] rand_data,
  input  logic [1:0]       lfsr_bits,
  output logic             lfsr_en,
  output logic             lfsr_load,
  output logic [7:0]       lfsr_seed
);

  localparam int DRAWS = OUT_W / 2;
  localparam int IW    = grant_w(NREQ);
  localparam int CW    = grant_w(DRAWS);

  logic [1:0]       state;
  logic [IW-1:0]    grant;
  logic [IW-1:0]    last_grant;
  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic             found;
  logic [IW-1:0]    pick_idx;
  logic             req_g;
  logic             draw_last;
  logic             grant_ok;

  rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .found     (found),
    .idx       (pick_idx)
  );

  assign req_g     = req[grant];
  assign draw_last = (cnt == CW'(DRAWS - 1));
  assign acc_next  = OUT_W'({acc, lfsr_bits});
  // Gated by the held request so an aborting cycle does not step the LFSR.
  assign lfsr_en   = (state == DRAW) && req_g;

`ifdef RAND_RESEED_EN
  logic [7:0] cyc_cnt;
  logic       pending;

  assign lfsr_load = (state == IDLE) && pending;
  assign lfsr_seed = cyc_cnt | 8'h01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      pending <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 8'd1;
      pending <= (pending && !lfsr_load) || reseed;
    end
  end
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = SEED_DEFAULT;
`endif

  assign grant_ok = found && !lfsr_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NREQ - 1);
      cnt        <= '0;
      acc        <= '0;
      ack        <= '0;
      rand_data  <= '0;
    end else begin
      ack       <= '0;
      rand_data <= '0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            grant <= pick_idx;
            cnt   <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (!req_g) begin
            state <= IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (draw_last) begin
              state     <= DONE;
              ack       <= {{(NREQ-1){1'b0}}, 1'b1} << grant;
              rand_data <= acc_next;
            end
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_scheduler.sv
// Self-checking bench for rand_scheduler: external LFSR harness plus a transaction-level
// reference model (round-robin order, word = concatenated 2-bit draws of the LFSR sequence).
module tb_rand_scheduler;
  import rand_pkg::*;

  localparam int NREQ  = 4;
  localparam int OUT_W = 8;
  localparam int DRAWS = OUT_W / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  ack;
  logic [OUT_W-1:0] rand_data;
  logic [1:0]       lfsr_bits;
  logic             lfsr_en;
  logic             lfsr_load;
  logic [7:0]       lfsr_seed;
`ifdef RAND_RESEED_EN
  logic             reseed = 1'b0;
`endif

  logic [7:0] hw_lfsr = SEED_DEFAULT;
  logic [7:0] m_lfsr  = SEED_DEFAULT;
  int m_last   = NREQ - 1;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int ack_cnt  = 0;

  always #5 clk = ~clk;

  rand_scheduler #(
    .NREQ (NREQ),
    .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef RAND_RESEED_EN
    .reseed   (reseed),
`endif
    .req      (req),
    .ack      (ack),
    .rand_data(rand_data),
    .lfsr_bits(lfsr_bits),
    .lfsr_en  (lfsr_en),
    .lfsr_load(lfsr_load),
    .lfsr_seed(lfsr_seed)
  );

  // x^8+x^4+x^3+x^2+1, shifting toward the MSB; bits [7:6] feed the scheduler.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1]};
  endfunction

  assign lfsr_bits = hw_lfsr[7:6];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (lfsr_en) en_cnt <= en_cnt + 1;
    if (lfsr_load) hw_lfsr <= lfsr_seed;
    else if (lfsr_en) hw_lfsr <= lfsr_next(hw_lfsr);
  end

  always @(negedge clk) if (ack != '0) ack_cnt <= ack_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] m, input int last);
    logic [NREQ-1:0] sh;
    for (int k = 1; k <= NREQ; k++) begin
      sh = m >> ((last + k) % NREQ);
      if (sh[0]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_draw(output logic [OUT_W-1:0] w);
    w = '0;
    for (int d = 0; d < DRAWS; d++) begin
      w      = OUT_W'({w, m_lfsr[7:6]});
      m_lfsr = lfsr_next(m_lfsr);
    end
  endtask

  task automatic wait_ack(input string tag, output int idx, output int at);
    int n;
    n   = 0;
    idx = -1;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 40);
    check({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
    for (int i = 0; i < NREQ; i++)
      if (ack == (NREQ'(1) << i)) idx = i;
    at = cyc;
  endtask

  task automatic expect_grant(input string tag, input logic [NREQ-1:0] mask,
                              input int t_ref, input int lat_exp, output int at);
    int g_exp, idx, e0;
    logic [OUT_W-1:0] w;
    g_exp = rr_model(mask, m_last);
    model_draw(w);
    e0 = en_cnt;
    wait_ack(tag, idx, at);
    check({tag, "_idx"}, idx, g_exp);
    check({tag, "_data"}, rand_data, w);
    check({tag, "_lat"}, at - t_ref, lat_exp);
    check({tag, "_steps"}, en_cnt - e0, DRAWS);
    m_last = g_exp;
  endtask

  initial begin
    int at, at_prev, e0, a0, k, idx, g;
    logic [NREQ-1:0] m;
    logic [OUT_W-1:0] w;

    repeat (3) @(negedge clk);
    check("rst_ack", ack, '0);
    check("rst_data", rand_data, '0);
    check("rst_en", lfsr_en, 1'b0);
    check("rst_load", lfsr_load, 1'b0);
`ifndef RAND_RESEED_EN
    check("seed_default", lfsr_seed, 8'hBD);
`endif
    rst = 1'b1;
    @(negedge clk);

    // single requester, then immediate re-request
    req = 4'b0001;
    expect_grant("t1", req, cyc, DRAWS + 1, at);
    check("t1_word", rand_data, 8'h9F);
    at_prev = at;
    expect_grant("t2", req, at_prev, DRAWS + 2, at);
    check("t2_word", rand_data, 8'hE7);
    req = '0;
    @(negedge clk);
    check("post_ack_ack", ack, '0);
    check("post_ack_data", rand_data, '0);

    e0 = en_cnt;
    repeat (4) @(negedge clk);
    check("idle_no_step", en_cnt - e0, 0);
    check("idle_lfsr", hw_lfsr, m_lfsr);

    // all requesters held continuously
    req = '1;
    at_prev = cyc;
    for (int i = 0; i < 5; i++) begin
      expect_grant("rr", req, at_prev, (i == 0) ? DRAWS + 1 : DRAWS + 2, at);
      at_prev = at;
    end
    req = '0;
    @(negedge clk);

    // abort after two draw cycles
    req = 4'b0100;
    e0 = en_cnt;
    a0 = ack_cnt;
    repeat (3) @(negedge clk);
    check("abort_en", lfsr_en, 1'b1);
    req = '0;
    #1 check("abort_en_drop", lfsr_en, 1'b0);
    repeat (8) @(negedge clk);
    check("abort_no_ack", ack_cnt - a0, 0);
    check("abort_steps", en_cnt - e0, 2);
    repeat (2) m_lfsr = lfsr_next(m_lfsr);
    check("abort_lfsr", hw_lfsr, m_lfsr);
    req = '1;
    expect_grant("after_abort", req, cyc, DRAWS + 1, at);
    req = '0;
    @(negedge clk);

    // randomized grants and aborts
    for (int it = 0; it < 24; it++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      if ($urandom_range(0, 3) == 0) begin
        k  = int'($urandom_range(0, DRAWS - 1));
        req = m;
        e0 = en_cnt;
        a0 = ack_cnt;
        repeat (k + 1) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        check("rand_abort_no_ack", ack_cnt - a0, 0);
        check("rand_abort_steps", en_cnt - e0, k);
        repeat (k) m_lfsr = lfsr_next(m_lfsr);
      end else begin
        req = m;
        expect_grant("rand", m, cyc, DRAWS + 1, at);
        req = '0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    check("rand_lfsr", hw_lfsr, m_lfsr);

    // reset in the middle of a draw
    req = 4'b0010;
    expect_grant("pre_rst", req, cyc, DRAWS + 1, at);
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ack", ack, '0);
    check("midrst_en", lfsr_en, 1'b0);
    check("midrst_data", rand_data, '0);
    m_lfsr = lfsr_next(m_lfsr);
    m_last = NREQ - 1;
    req = '1;
    @(negedge clk);
    rst = 1'b1;
    expect_grant("post_rst", req, cyc, DRAWS + 1, at);
    req = '0;
    @(negedge clk);

`ifdef RAND_RESEED_EN
    // reseed pulse during a draw is served in the next idle cycle
    req = 4'b0001;
    g = rr_model(req, m_last);
    model_draw(w);
    repeat (2) @(negedge clk);
    reseed = 1'b1;
    req = 4'b0011;
    @(negedge clk);
    reseed = 1'b0;
    wait_ack("reseed_first", idx, at);
    check("reseed_first_idx", idx, g);
    check("reseed_first_data", rand_data, w);
    check("reseed_hold", lfsr_load, 1'b0);
    m_last = g;
    req = 4'b0010;
    @(negedge clk);
    check("reseed_load", lfsr_load, 1'b1);
    check("reseed_seed_lsb", lfsr_seed[0], 1'b1);
    check("reseed_no_step", lfsr_en, 1'b0);
    m_lfsr = lfsr_seed;
    expect_grant("reseed_grant", req, cyc, DRAWS + 2, at);
    req = '0;
    @(negedge clk);
`endif

    check("final_lfsr", hw_lfsr, m_lfsr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
